// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and memory command payload for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 2;

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = 8'd255;

    localparam logic [ST_W-1:0] IDLE   = 2'd0;
    localparam logic [ST_W-1:0] BUSY_D = 2'd1;
    localparam logic [ST_W-1:0] BUSY_F = 2'd2;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle counter for an outstanding memory access, raising a sticky timeout when the limit is hit.
module mem_watchdog
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic busy,
    input  logic ack,
    output logic expire_c,
    output logic timeout
);

    logic [CNT_W-1:0] busy_cnt;

    // True on the edge where the counter would reach the limit without an ack.
    assign expire_c = busy & ~ack & (busy_cnt == TIMEOUT_LIMIT - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (issue) begin
                busy_cnt <= '0;
            end else if (busy && !ack && (busy_cnt != TIMEOUT_LIMIT)) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (expire_c) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one memory port between the data (priority) and fetch requesters.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            FetchReq,
    input  logic [XLEN-1:0] FetchAddr,
    output logic [XLEN-1:0] FetchRData,
    output logic            FetchValid,
    input  logic            DataReq,
    input  logic            DataWe,
    input  logic [XLEN-1:0] DataAddr,
    input  logic [XLEN-1:0] DataWData,
    output logic [XLEN-1:0] DataRData,
    output logic            DataValid,
    output logic            MemReq,
    output logic            MemWe,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWData,
    input  logic [XLEN-1:0] MemRData,
    input  logic            MemAck,
    output logic            StallFetch,
    output logic            StallData,
    output logic            Timeout
);

    logic [ST_W-1:0] state, state_n;
    mem_cmd_t        cmd, cmd_n;
    logic            mem_req_n;
    logic            dvalid_n, fvalid_n;
    logic [XLEN-1:0] drdata_n, frdata_n;
    logic            data_pend_c, fetch_pend_c;
    logic            issue_c, busy_c, expire_c;

    // A request still visible during its own Valid cycle is the one just served, not a new one.
    assign data_pend_c  = DataReq & ~DataValid;
    assign fetch_pend_c = FetchReq & ~FetchValid;
    assign issue_c      = (state == IDLE) & (data_pend_c | fetch_pend_c);
    assign busy_c       = (state != IDLE);

    assign StallData  = data_pend_c;
    assign StallFetch = fetch_pend_c;

    assign MemWe    = cmd.we;
    assign MemAddr  = cmd.addr;
    assign MemWData = cmd.wdata;

    always_comb begin
        state_n   = state;
        cmd_n     = cmd;
        mem_req_n = MemReq;
        dvalid_n  = 1'b0;
        fvalid_n  = 1'b0;
        drdata_n  = DataRData;
        frdata_n  = FetchRData;
        case (state)
            IDLE: begin
                if (data_pend_c) begin
                    cmd_n     = '{we: DataWe, addr: DataAddr, wdata: DataWData};
                    mem_req_n = 1'b1;
                    state_n   = BUSY_D;
                end else if (fetch_pend_c) begin
                    cmd_n.we   = 1'b0;
                    cmd_n.addr = FetchAddr;
                    mem_req_n  = 1'b1;
                    state_n    = BUSY_F;
                end
            end
            BUSY_D: begin
                if (MemAck) begin
                    if (!cmd.we) begin
                        drdata_n = MemRData;
                    end
                    dvalid_n  = 1'b1;
                    mem_req_n = 1'b0;
                    state_n   = IDLE;
                end else if (expire_c) begin
                    mem_req_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            BUSY_F: begin
                if (MemAck) begin
                    // A redirected fetch drops the stale word; IDLE reissues at the new address.
                    if (FetchReq && (FetchAddr == cmd.addr)) begin
                        frdata_n = MemRData;
                        fvalid_n = 1'b1;
                    end
                    mem_req_n = 1'b0;
                    state_n   = IDLE;
                end else if (expire_c) begin
                    mem_req_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: begin
                mem_req_n = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= '0;
            MemReq     <= 1'b0;
            DataValid  <= 1'b0;
            FetchValid <= 1'b0;
            DataRData  <= '0;
            FetchRData <= '0;
        end else begin
            state      <= state_n;
            cmd        <= cmd_n;
            MemReq     <= mem_req_n;
            DataValid  <= dvalid_n;
            FetchValid <= fvalid_n;
            DataRData  <= drdata_n;
            FetchRData <= frdata_n;
        end
    end

    mem_watchdog u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue_c),
        .busy     (busy_c),
        .ack      (MemAck),
        .expire_c (expire_c),
        .timeout  (Timeout)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model, memory responder and directed scenarios.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        FetchReq = 1'b0;
    logic [31:0] FetchAddr = '0;
    logic [31:0] FetchRData;
    logic        FetchValid;
    logic        DataReq = 1'b0;
    logic        DataWe = 1'b0;
    logic [31:0] DataAddr = '0;
    logic [31:0] DataWData = '0;
    logic [31:0] DataRData;
    logic        DataValid;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData = '0;
    logic        MemAck = 1'b0;
    logic        StallFetch;
    logic        StallData;
    logic        Timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .FetchReq   (FetchReq),
        .FetchAddr  (FetchAddr),
        .FetchRData (FetchRData),
        .FetchValid (FetchValid),
        .DataReq    (DataReq),
        .DataWe     (DataWe),
        .DataAddr   (DataAddr),
        .DataWData  (DataWData),
        .DataRData  (DataRData),
        .DataValid  (DataValid),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemRData   (MemRData),
        .MemAck     (MemAck),
        .StallFetch (StallFetch),
        .StallData  (StallData),
        .Timeout    (Timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h40) return 32'h0050_0093;
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory responder: acks in the ack_lat-th cycle that MemReq is high (0 = never).
    int ack_lat   = 1;
    int hold      = 0;
    bit force_ack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (MemReq === 1'b1) begin
            hold++;
            MemAck = (ack_lat != 0) && (hold == ack_lat);
        end else begin
            hold   = 0;
            MemAck = force_ack;
        end
        MemRData = rdata_for(MemAddr);
    end

    // Transaction-level model: at most one outstanding access, described by its record.
    bit          live = 1'b0;
    bit          t_busy = 1'b0, t_is_data = 1'b0, t_we = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    int          t_wait = 0;
    bit          m_dv = 1'b0, m_fv = 1'b0, m_timeout = 1'b0;
    logic [31:0] m_drdata = '0, m_frdata = '0;
    bit          dv_n, fv_n;
    bit          p_rst = 1'b1, p_dreq = 1'b0, p_dv = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;

    always @(posedge clk) begin
        // Requester must hold the data request until it has seen DataValid.
        if (!rst && !p_rst && p_dreq && !p_dv)
            check("data_req_hold", 32'(DataReq === 1'b1 && DataWe === p_we &&
                  DataAddr === p_addr && DataWData === p_wdata), 32'd1);
        p_rst = rst; p_dreq = DataReq; p_dv = m_dv;
        p_we = DataWe; p_addr = DataAddr; p_wdata = DataWData;

        if (rst) begin
            live = 1'b1;
            t_busy = 1'b0; t_is_data = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_wait = 0;
            m_dv = 1'b0; m_fv = 1'b0; m_timeout = 1'b0; m_drdata = '0; m_frdata = '0;
        end else begin
            dv_n = 1'b0;
            fv_n = 1'b0;
            if (!t_busy) begin
                if (DataReq && !m_dv) begin
                    t_busy = 1'b1; t_is_data = 1'b1; t_we = DataWe;
                    t_addr = DataAddr; t_wdata = DataWData; t_wait = 0;
                end else if (FetchReq && !m_fv) begin
                    t_busy = 1'b1; t_is_data = 1'b0; t_we = 1'b0;
                    t_addr = FetchAddr; t_wait = 0;
                end
            end else if (MemAck) begin
                t_busy = 1'b0;
                if (t_is_data) begin
                    dv_n = 1'b1;
                    if (!t_we) m_drdata = MemRData;
                end else if (FetchReq && FetchAddr == t_addr) begin
                    fv_n = 1'b1;
                    m_frdata = MemRData;
                end
            end else begin
                t_wait++;
                if (t_wait == 255) begin
                    m_timeout = 1'b1;
                    t_busy = 1'b0;
                end
            end
            m_dv = dv_n;
            m_fv = fv_n;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("model_MemReq", 32'(MemReq), 32'(t_busy));
            if (t_busy) begin
                check("model_MemAddr", MemAddr, t_addr);
                check("model_MemWe", 32'(MemWe), 32'(t_we));
                if (t_is_data && t_we) check("model_MemWData", MemWData, t_wdata);
            end
            check("model_DataValid", 32'(DataValid), 32'(m_dv));
            check("model_FetchValid", 32'(FetchValid), 32'(m_fv));
            check("model_DataRData", DataRData, m_drdata);
            check("model_FetchRData", FetchRData, m_frdata);
            check("model_Timeout", 32'(Timeout), 32'(m_timeout));
            check("model_StallData", 32'(StallData), 32'(DataReq & ~m_dv));
            check("model_StallFetch", 32'(StallFetch), 32'(FetchReq & ~m_fv));
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic nb();
        @(negedge clk);
    endtask

    initial begin
        int n;

        // Reset values
        repeat (2) @(posedge clk);
        nb();
        check("rst_MemReq", 32'(MemReq), 32'd0);
        check("rst_MemWe", 32'(MemWe), 32'd0);
        check("rst_MemAddr", MemAddr, 32'd0);
        check("rst_MemWData", MemWData, 32'd0);
        check("rst_FetchRData", FetchRData, 32'd0);
        check("rst_DataRData", DataRData, 32'd0);
        check("rst_Valids", 32'({FetchValid, DataValid}), 32'd0);
        check("rst_Timeout", 32'(Timeout), 32'd0);
        go(); rst = 1'b0;
        go();

        // Single fetch with minimum latency
        FetchReq = 1'b1; FetchAddr = 32'h40; ack_lat = 1;
        nb(); check("f1_stall_before", 32'(StallFetch), 32'd1);
        nb(); check("f1_memreq", 32'(MemReq), 32'd1);
              check("f1_memaddr", MemAddr, 32'h40);
              check("f1_memwe", 32'(MemWe), 32'd0);
        nb(); check("f1_valid", 32'(FetchValid), 32'd1);
              check("f1_rdata", FetchRData, 32'h0050_0093);
              check("f1_stall_valid", 32'(StallFetch), 32'd0);
        go(); FetchReq = 1'b0;
        nb(); check("f1_valid_once", 32'(FetchValid), 32'd0);
              check("f1_no_reissue", 32'(MemReq), 32'd0);

        // Data and fetch together: data first
        go();
        DataReq = 1'b1; DataWe = 1'b0; DataAddr = 32'h100; DataWData = '0;
        FetchReq = 1'b1; FetchAddr = 32'h44;
        nb(); check("p_stalls", 32'({StallData, StallFetch}), 32'b11);
        nb(); check("p_addr_data", MemAddr, 32'h100);
              check("p_stallf_1", 32'(StallFetch), 32'd1);
        nb(); check("p_dvalid", 32'(DataValid), 32'd1);
              check("p_drdata", DataRData, 32'hFEFF_0100);
              check("p_stallf_2", 32'(StallFetch), 32'd1);
        go(); DataReq = 1'b0;
        nb(); check("p_addr_fetch", MemAddr, 32'h44);
              check("p_memreq_f", 32'(MemReq), 32'd1);
        nb(); check("p_fvalid", 32'(FetchValid), 32'd1);
              check("p_frdata", FetchRData, 32'hFFBB_0044);
        go(); FetchReq = 1'b0;
        nb();

        // Store with ack in the third cycle
        go();
        DataReq = 1'b1; DataWe = 1'b1; DataAddr = 32'h200; DataWData = 32'hDEAD_BEEF; ack_lat = 3;
        nb();
        for (int i = 0; i < 3; i++) begin
            nb();
            check("st_memwe", 32'(MemWe), 32'd1);
            check("st_addr", MemAddr, 32'h200);
            check("st_wdata", MemWData, 32'hDEAD_BEEF);
            check("st_no_valid", 32'(DataValid), 32'd0);
        end
        nb(); check("st_dvalid", 32'(DataValid), 32'd1);
              check("st_drdata_kept", DataRData, 32'hFEFF_0100);
        go(); DataReq = 1'b0; DataWe = 1'b0;
        nb(); check("st_valid_once", 32'(DataValid), 32'd0);

        // Fetch redirected while in flight
        go();
        FetchReq = 1'b1; FetchAddr = 32'h48; ack_lat = 2;
        nb();
        nb(); check("rd_addr48", MemAddr, 32'h48);
        go(); FetchAddr = 32'h80;
        nb(); check("rd_addr48_stable", MemAddr, 32'h48);
        nb(); check("rd_dropped", 32'(FetchValid), 32'd0);
        nb(); check("rd_reissue", 32'(MemReq), 32'd1);
              check("rd_addr80", MemAddr, 32'h80);
        nb();
        nb(); check("rd_fvalid", 32'(FetchValid), 32'd1);
              check("rd_frdata", FetchRData, 32'hFF7F_0080);
        go(); FetchReq = 1'b0;

        // Ack while idle is ignored
        force_ack = 1'b1;
        go();
        for (int i = 0; i < 3; i++) begin
            nb();
            check("idle_ack", 32'({MemReq, DataValid, FetchValid}), 32'd0);
        end
        force_ack = 1'b0;
        go(); go();

        // No ack: timeout after 255 busy cycles
        FetchReq = 1'b1; FetchAddr = 32'h300; ack_lat = 0;
        go(); FetchReq = 1'b0;
        n = 0;
        while (MemReq === 1'b1 && n < 400) begin
            n++;
            if (n == 254) check("to_not_yet", 32'(Timeout), 32'd0);
            go();
        end
        check("to_busy_cycles", 32'(n), 32'd255);
        check("to_set", 32'(Timeout), 32'd1);
        check("to_memreq_low", 32'(MemReq), 32'd0);
        ack_lat = 1; FetchReq = 1'b1; FetchAddr = 32'h40;
        go(); go();
        check("to_fetch_after", 32'(FetchValid), 32'd1);
        go(); FetchReq = 1'b0;
        go();
        check("to_sticky", 32'(Timeout), 32'd1);
        rst = 1'b1;
        go();
        check("to_cleared", 32'(Timeout), 32'd0);
        rst = 1'b0;
        go();

        // Reset while a data access is outstanding
        ack_lat = 0; DataReq = 1'b1; DataWe = 1'b0; DataAddr = 32'h400;
        go(); check("rm_busy", 32'(MemReq), 32'd1);
        go(); rst = 1'b1; DataReq = 1'b0;
        go(); check("rm_memreq", 32'(MemReq), 32'd0);
              check("rm_dvalid", 32'(DataValid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            go();
            check("rm_quiet", 32'({MemReq, DataValid}), 32'd0);
        end
        ack_lat = 1; DataReq = 1'b1; DataAddr = 32'h100;
        go(); go();
        check("rm_after_valid", 32'(DataValid), 32'd1);
        check("rm_after_rdata", DataRData, 32'hFEFF_0100);
        go(); DataReq = 1'b0;
        go(); go();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_time_limit: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
